uart_result_tx: RTL and testbench

Return-path UART transmitter for the CNN accelerator board top. It accepts the 4-bit classification result from the inference core, alongside the existing 7-segment result path, and sends it to the host as a 3-byte ASCII line: the digit, then CR, then LF. Framing is 8N1 on `tx_pin_out`, matching the receive-side UART settings. A one-entry pending register absorbs a result that arrives while a line is still being sent.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_byte.sv | 60 ++++++
 rtl/uart_result_tx.sv | 71 +++++++
 tb/tb_uart_result_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, state encodings and helpers for the board-top UARTs.
package uart_pkg;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  typedef enum logic [1:0] {LN_IDLE, SEND_CHAR, SEND_CR, SEND_LF} line_state_t;
  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
  function automatic logic [7:0] to_ascii(input logic [3:0] r);
    return r <= 4'd9 ? ASCII_0 + {4'd0, r} : ASCII_A + {4'd0, r} - 8'd10;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; a start seen at the end of a stop bit chains the next byte with no gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  ser_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic bit_end;
  assign bit_end = cnt == LAST;
  assign done = state == SER_STOP && bit_end;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= SER_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      cnt <= (state == SER_IDLE || bit_end) ? '0 : cnt + CW'(1);
      case (state)
        SER_IDLE: if (start) begin
          state <= SER_START;
          sh <= data;
          tx <= 1'b0;
          busy <= 1'b1;
        end
        SER_START: if (bit_end) begin
          state <= SER_DATA;
          idx <= '0;
          tx <= sh[0];
        end
        SER_DATA: if (bit_end) begin
          sh <= sh >> 1;
          idx <= idx + 3'd1;
          state <= idx == 3'd7 ? SER_STOP : SER_DATA;
          tx <= idx == 3'd7 ? 1'b1 : sh[1];
        end
        SER_STOP: if (bit_end) begin
          state <= start ? SER_START : SER_IDLE;
          sh <= data;
          tx <= !start;
          busy <= start;
        end
      endcase
    end
endmodule

// File: rtl/uart_result_tx.sv
// uart_result_tx: sends each 4-bit inference result as an ASCII "<digit>\r\n" line over 8N1.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] result_in,
  input  logic       result_valid,
  output logic       tx_pin_out,
  output logic       tx_busy,
  output logic       result_overflow
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  line_state_t state;
  logic start;
  logic done;
  logic [7:0] data;
  logic [3:0] pend;
  logic pend_v;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data (data),
    .busy (tx_busy),
    .done (done),
    .tx   (tx_pin_out)
  );
  // data always holds the byte the serializer will take at its next load point
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= LN_IDLE;
      start <= 1'b0;
      data <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      result_overflow <= 1'b0;
    end else begin
      result_overflow <= 1'b0;
      case (state)
        LN_IDLE: begin
          if (pend_v || result_valid) begin
            state <= SEND_CHAR;
            start <= 1'b1;
            data <= to_ascii(pend_v ? pend : result_in);
          end
          if (pend_v) begin
            pend_v <= result_valid;
            pend <= result_in;
          end
        end
        SEND_CHAR: begin
          data <= done ? LF : CR;
          state <= done ? SEND_CR : SEND_CHAR;
        end
        SEND_CR: if (done) begin
          state <= SEND_LF;
          start <= 1'b0;
        end
        SEND_LF: if (done) state <= LN_IDLE;
      endcase
      if (state != LN_IDLE && result_valid) begin
        pend <= result_in;
        pend_v <= 1'b1;
        result_overflow <= pend_v;
      end
    end
endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: random result lines decoded by a bit-centre UART receiver and compared to expected ASCII lines.
module tb_uart_result_tx;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] result_in = '0;
  logic result_valid = 1'b0;
  logic tx_pin_out, tx_busy, result_overflow;

  uart_result_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clock(clock),
    .reset(reset),
    .result_in(result_in),
    .result_valid(result_valid),
    .tx_pin_out(tx_pin_out),
    .tx_busy(tx_busy),
    .result_overflow(result_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int data;
    int start;
    int ok;
  } frame_t;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int ovf_cnt = 0;
  int ovf_cyc = -1;
  frame_t frames[$];
  int exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (result_overflow) begin
      ovf_cnt <= ovf_cnt + 1;
      ovf_cyc <= cyc;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ascii_of(input int r);
    return r < 10 ? 48 + r : 65 + (r - 10);
  endfunction

  task automatic push_line(input int r);
    exp_q.push_back(ascii_of(r));
    exp_q.push_back(13);
    exp_q.push_back(10);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // returns at the negedge where cyc == t, with the strobe sampled at edge t
  task automatic strobe_at(input int t, input int r);
    int n;
    n = 0;
    @(negedge clock);
    while (cyc < t - 1 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    result_in = 4'(r);
    result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
  endtask

  task automatic compare_lines(input string tag);
    check({tag, "_nbytes"}, frames.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
      check({tag, "_byte"}, frames[i].data, exp_q[i]);
      check({tag, "_framing"}, frames[i].ok, 1);
    end
    frames.delete();
    exp_q.delete();
  endtask

  // bit-centre receiver: start detected at first low negedge, centres every 10 cycles after +5
  initial begin
    frame_t f;
    forever begin
      @(negedge clock);
      if (reset && tx_pin_out === 1'b0) begin
        f.start = cyc;
        f.data = 0;
        f.ok = 1;
        repeat (5) @(negedge clock);
        if (tx_pin_out !== 1'b0) f.ok = 0;
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clock);
          if (tx_pin_out === 1'b1) f.data = f.data | (1 << k);
        end
        repeat (10) @(negedge clock);
        if (tx_pin_out !== 1'b1) f.ok = 0;
        frames.push_back(f);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    int s, b, o0, r, a, c, bad_tx, bad_busy;
    int rs[$];
    settle(3);
    check("reset_tx", tx_pin_out, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_ovf", result_overflow, 0);
    reset = 1'b1;
    settle(3);

    s = cyc + 2;
    strobe_at(s, 7);
    push_line(7);
    b = 0;
    repeat (400) begin
      @(negedge clock);
      b += int'(tx_busy);
    end
    check("busy_cycles", b, 300);
    if (frames.size() >= 3) begin
      check("start_latency", frames[0].start, s + 1);
      check("cr_no_gap", frames[1].start, s + 101);
      check("lf_no_gap", frames[2].start, s + 201);
    end
    compare_lines("line7");

    rs = '{10, 15};
    repeat (6) rs.push_back($urandom_range(0, 15));
    foreach (rs[i]) begin
      s = cyc + 2 + $urandom_range(0, 7);
      strobe_at(s, rs[i]);
      push_line(rs[i]);
      settle(330);
      if (frames.size() > 0) check("rand_start", frames[0].start, s + 1);
      compare_lines("rand_line");
    end

    o0 = ovf_cnt;
    s = cyc + 2;
    strobe_at(s, 3);
    strobe_at(s + 150, 5);
    settle(700);
    push_line(3);
    push_line(5);
    check("pend_no_ovf", ovf_cnt - o0, 0);
    if (frames.size() >= 4) check("pend_start", frames[3].start, frames[0].start + 302);
    compare_lines("pending");

    o0 = ovf_cnt;
    s = cyc + 2;
    strobe_at(s, 3);
    strobe_at(s + 50, 5);
    strobe_at(s + 150, 9);
    settle(700);
    push_line(3);
    push_line(9);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_cycle", ovf_cyc, s + 150);
    compare_lines("overwrite");

    o0 = ovf_cnt;
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    c = $urandom_range(0, 15);
    s = cyc + 2;
    strobe_at(s, a);
    strobe_at(s + 120, b);
    strobe_at(s + 302, c);
    settle(800);
    push_line(a);
    push_line(b);
    push_line(c);
    check("idle_pend_no_ovf", ovf_cnt - o0, 0);
    if (frames.size() >= 7) begin
      check("idle_pend_start_b", frames[3].start, s + 303);
      check("idle_pend_start_c", frames[6].start, s + 605);
    end
    compare_lines("idle_pending");

    r = $urandom_range(10, 15);
    s = cyc + 2;
    strobe_at(s, r);
    settle(55);
    check("mid_bit4_tx", tx_pin_out, 0);
    check("mid_bit4_busy", tx_busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", tx_pin_out, 1);
    check("async_reset_busy", tx_busy, 0);
    check("async_reset_ovf", result_overflow, 0);
    settle(3);
    reset = 1'b1;
    settle(150);
    frames.delete();
    exp_q.delete();
    s = cyc + 2;
    strobe_at(s, 2);
    push_line(2);
    settle(330);
    if (frames.size() > 0) check("post_reset_start", frames[0].start, s + 1);
    compare_lines("post_reset");

    o0 = ovf_cnt;
    bad_tx = 0;
    bad_busy = 0;
    repeat (1000) begin
      @(negedge clock);
      if (tx_pin_out !== 1'b1) bad_tx++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    check("idle_tx_low", bad_tx, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_ovf", ovf_cnt - o0, 0);
    check("idle_frames", frames.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
